// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_pkg                                                |
// | Description : Operation codes, FSM state encoding and decode helpers |
// |               shared by the multi-cycle ALU and its iterative unit.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'h00,
        OP_SUB    = 5'h01,
        OP_SLL    = 5'h02,
        OP_SRL    = 5'h03,
        OP_SRA    = 5'h04,
        OP_SLT    = 5'h05,
        OP_SLTU   = 5'h06,
        OP_XOR    = 5'h07,
        OP_OR     = 5'h08,
        OP_AND    = 5'h09,
        OP_PASS_B = 5'h0A,
        OP_MUL    = 5'h0B,
        OP_MULH   = 5'h0C,
        OP_MULHU  = 5'h0D,
        OP_DIV    = 5'h0E,
        OP_DIVU   = 5'h0F,
        OP_REM    = 5'h10,
        OP_REMU   = 5'h11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    // Multiply/divide family: routed through the shared iterative datapath.
    function automatic logic is_iterative(input logic [4:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

    // Divide/remainder family: needs the divide-by-zero short cut.
    function automatic logic is_divide(input logic [4:0] op);
        return (op >= OP_DIV) && (op <= OP_REMU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_muldiv_iter                                        |
// | Description : Shared radix-2 shift-add multiplier / restoring        |
// |               divider. Runs WIDTH iterations on operand magnitudes   |
// |               and applies the sign correction on the last one.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             kill,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_op;
    logic             r_is_div;
    logic             r_neg;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;

    logic             w_signed;
    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_next_hi;
    logic [WIDTH-1:0] w_next_lo;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0] w_quot_fix;
    logic [WIDTH-1:0] w_rem_fix;

    // Magnitudes for the signed flavours; MUL low half is sign-agnostic.
    assign w_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign w_neg_a  = w_signed && a[WIDTH-1];
    assign w_neg_b  = w_signed && b[WIDTH-1];
    assign w_mag_a  = w_neg_a ? (~a + 1'b1) : a;
    assign w_mag_b  = w_neg_b ? (~b + 1'b1) : b;

    // One shift-add multiply step: hi accumulates, lo shifts out multiplier.
    assign w_add = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);

    // One restoring divide step: shift in next dividend bit, trial subtract.
    assign w_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_b});
    assign w_sub   = w_shift[WIDTH-1:0] - r_b;

    // Next register values for whichever algorithm is running.
    always_comb begin
        w_next_hi = r_hi;
        w_next_lo = r_lo;
        if (r_is_div) begin
            w_next_hi = w_ge ? w_sub : w_shift[WIDTH-1:0];
            w_next_lo = {r_lo[WIDTH-2:0], w_ge};
        end else begin
            w_next_hi = w_add[WIDTH:1];
            w_next_lo = {w_add[0], r_lo[WIDTH-1:1]};
        end
    end

    // Sign correction applied to the post-step values so the final
    // iteration's outcome is available to the caller in the same cycle.
    assign w_prod_fix = r_neg ? (~{w_next_hi, w_next_lo} + 1'b1) : {w_next_hi, w_next_lo};
    assign w_quot_fix = r_neg ? (~w_next_lo + 1'b1) : w_next_lo;
    assign w_rem_fix  = r_neg ? (~w_next_hi + 1'b1) : w_next_hi;

    // Select the requested part of the finished computation.
    always_comb begin
        result = '0;
        case (r_op)
            OP_MUL:            result = w_prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHU: result = w_prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:   result = w_quot_fix;
            OP_REM, OP_REMU:   result = w_rem_fix;
            default:           result = '0;
        endcase
    end

    assign busy = r_busy;
    assign done = r_busy && (r_cnt == c_cnt_one);

    // Load on start, then iterate with a down-counter until the last step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_op     <= 5'h00;
            r_is_div <= 1'b0;
            r_neg    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
        end else if (kill) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_cnt    <= c_cnt_load;
            r_op     <= op;
            r_is_div <= is_divide(op);
            r_neg    <= (op == OP_REM) ? w_neg_a : (w_neg_a ^ w_neg_b);
            r_hi     <= '0;
            r_lo     <= w_mag_a;
            r_b      <= w_mag_b;
        end else if (r_busy) begin
            r_hi  <= w_next_hi;
            r_lo  <= w_next_lo;
            r_cnt <= r_cnt - c_cnt_one;
            if (r_cnt == c_cnt_one) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_mc                                                 |
// | Description : Multi-cycle integer ALU with valid/ready handshakes.   |
// |               Base ops complete in one cycle; multiply/divide use    |
// |               the shared iterative unit. Results/flags registered.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int CNT_W   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       operation,
    input  logic [WIDTH-1:0] operand_A,
    input  logic [WIDTH-1:0] operand_B,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero
);

    alu_state_e       r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_overflow;
    logic             r_div_by_zero;

    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_div_zero;
    logic               w_start;
    logic [WIDTH-1:0]   w_base_result;
    logic               w_base_overflow;
    logic               w_iter_busy;
    logic               w_iter_done;
    logic [WIDTH-1:0]   w_iter_result;

    assign w_sum      = operand_A + operand_B;
    assign w_diff     = operand_A - operand_B;
    assign w_shamt    = operand_B[SHAMT_W-1:0];
    assign w_div_zero = is_divide(operation) && (operand_B == '0);
    // Long ops with a usable divisor launch the iterative unit on acceptance.
    assign w_start    = r_in_ready && in_valid && !flush &&
                        is_iterative(operation) && !w_div_zero;

    // Single-cycle results, including the divide-by-zero short cut.
    always_comb begin
        w_base_result   = '0;
        w_base_overflow = 1'b0;
        case (operation)
            OP_ADD: begin
                w_base_result   = w_sum;
                w_base_overflow = (operand_A[WIDTH-1] == operand_B[WIDTH-1]) &&
                                  (w_sum[WIDTH-1] != operand_A[WIDTH-1]);
            end
            OP_SUB: begin
                w_base_result   = w_diff;
                w_base_overflow = (operand_A[WIDTH-1] != operand_B[WIDTH-1]) &&
                                  (w_diff[WIDTH-1] != operand_A[WIDTH-1]);
            end
            OP_SLL:    w_base_result = operand_A << w_shamt;
            OP_SRL:    w_base_result = operand_A >> w_shamt;
            OP_SRA:    w_base_result = $signed(operand_A) >>> w_shamt;
            OP_SLT:    w_base_result = {{(WIDTH-1){1'b0}}, ($signed(operand_A) < $signed(operand_B))};
            OP_SLTU:   w_base_result = {{(WIDTH-1){1'b0}}, (operand_A < operand_B)};
            OP_XOR:    w_base_result = operand_A ^ operand_B;
            OP_OR:     w_base_result = operand_A | operand_B;
            OP_AND:    w_base_result = operand_A & operand_B;
            OP_PASS_B: w_base_result = operand_B;
            OP_DIV, OP_DIVU: w_base_result = '1;
            OP_REM, OP_REMU: w_base_result = operand_A;
            default:   w_base_result = '0;
        endcase
    end

    alu_muldiv_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (w_start),
        .kill   (flush),
        .op     (operation),
        .a      (operand_A),
        .b      (operand_B),
        .busy   (w_iter_busy),
        .done   (w_iter_done),
        .result (w_iter_result)
    );

    // Control FSM and output registers; flush outranks accept and complete.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_result      <= '0;
            r_zero        <= 1'b0;
            r_overflow    <= 1'b0;
            r_div_by_zero <= 1'b0;
        end else if (flush) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_in_ready <= 1'b0;
                        if (w_start) begin
                            r_state <= ST_BUSY;
                        end else begin
                            r_state       <= ST_DONE;
                            r_out_valid   <= 1'b1;
                            r_result      <= w_base_result;
                            r_zero        <= (w_base_result == '0);
                            r_overflow    <= w_base_overflow;
                            r_div_by_zero <= w_div_zero;
                        end
                    end
                end
                ST_BUSY: begin
                    if (w_iter_done) begin
                        r_state       <= ST_DONE;
                        r_out_valid   <= 1'b1;
                        r_result      <= w_iter_result;
                        r_zero        <= (w_iter_result == '0);
                        r_overflow    <= 1'b0;
                        r_div_by_zero <= 1'b0;
                    end else if (!w_iter_busy) begin
                        // Unit idle with no result: never wait forever on it.
                        r_state    <= ST_IDLE;
                        r_in_ready <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign result      = r_result;
    assign zero        = r_zero;
    assign overflow    = r_overflow;
    assign div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire
